// File: rtl/mem_bus_arb_pkg.sv
// Shared types and default sizing for the two-master data-bus arbiter.
package mem_arb_pkg;

    localparam int ARB_AW       = 16;
    localparam int ARB_DW       = 32;
    localparam int ARB_RD_LAT   = 1;
    localparam int ARB_MAX_HOLD = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // 0 = CPU (m0), 1 = accelerator (m1)
    typedef logic mst_id_t;

endpackage

// File: rtl/mem_bus_arb_if.sv
// One master's view of the memory-mapped data bus.
// The master drives the request side; the arbiter answers with grant and read return.
interface mem_bus_arb_if import mem_arb_pkg::*; #(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          lock;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, lock,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_bus_arb_rd_tag_pipe.sv
// Read-tag delay line: carries {valid, master id} alongside the slave's read latency
// so returning data can be steered to whoever issued the read.
module rd_tag_pipe import mem_arb_pkg::*; #(
    parameter int RD_LAT = ARB_RD_LAT
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  mst_id_t i_id,
    output logic    o_vld,
    output mst_id_t o_id
);
    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_id;

    // Valid bits shift every cycle; reset flushes every in-flight tag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_push;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // Ids only matter when their valid is set, so they shift without reset
    always_ff @(posedge clk) begin
        r_id[0] <= i_id;
        for (int i = 1; i < RD_LAT; i++) begin
            r_id[i] <= r_id[i-1];
        end
    end

    assign o_vld = r_vld[RD_LAT-1];
    assign o_id  = r_id[RD_LAT-1];

endmodule

// File: rtl/mem_bus_arb.sv
// Two-master round-robin arbiter for the CPU data bus with bounded hold and lock.
// Read data returns to the issuing master RD_LAT+1 cycles after the slave strobe.
module mem_bus_arb import mem_arb_pkg::*; #(
    parameter int AW       = ARB_AW,
    parameter int DW       = ARB_DW,
    parameter int RD_LAT   = ARB_RD_LAT,
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic          clk,
    input  logic          rst,
    mem_bus_arb_if.slave  m0,
    mem_bus_arb_if.slave  m1,
    output logic [AW-1:0] s_addr,
    output logic          s_re,
    output logic          s_we,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_e    r_state;
    mst_id_t       r_prio;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_inc;
    logic          w_hold_done;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_tag_vld;
    mst_id_t       w_tag_id;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata;

    // Counter saturates so a long lock cannot wrap it back below the limit
    assign w_hold_inc  = (r_hold == HW'(MAX_HOLD)) ? r_hold : r_hold + 1'b1;
    // True when the grant in this cycle is the owner's MAX_HOLD-th
    assign w_hold_done = (r_hold >= HW'(MAX_HOLD - 1));

    // Owner is granted on its own request; an idle owner hands the slot over at once
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            OWN0: begin
                w_gnt0 = m0.req;
                w_gnt1 = ~m0.req & m1.req;
            end
            OWN1: begin
                w_gnt1 = m1.req;
                w_gnt0 = ~m1.req & m0.req;
            end
            default: ;
        endcase
    end

    // Route the granted master onto the slave bus; quiet bus otherwise
    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_re    = 1'b0;
        s_we    = 1'b0;
        if (w_gnt0) begin
            s_addr  = m0.addr;
            s_wdata = m0.wdata;
            s_re    = ~m0.we;
            s_we    = m0.we;
        end else if (w_gnt1) begin
            s_addr  = m1.addr;
            s_wdata = m1.wdata;
            s_re    = ~m1.we;
            s_we    = m1.we;
        end
    end

    // Ownership FSM with round-robin pointer and hold counter.
    // A handoff cycle already grants the new owner, so its count starts at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_hold <= '0;
                    if (m0.req && (!m1.req || r_prio == 1'b0)) begin
                        r_state <= OWN0;
                        r_prio  <= 1'b1;
                    end else if (m1.req) begin
                        r_state <= OWN1;
                        r_prio  <= 1'b0;
                    end
                end
                OWN0: begin
                    if (!m0.req) begin
                        if (m1.req) begin
                            r_state <= OWN1;
                            r_prio  <= 1'b0;
                            r_hold  <= HW'(1);
                        end else begin
                            r_state <= IDLE;
                            r_hold  <= '0;
                        end
                    end else if (w_hold_done && m1.req && !m0.lock) begin
                        r_state <= OWN1;
                        r_prio  <= 1'b0;
                        r_hold  <= '0;
                    end else begin
                        r_hold <= w_hold_inc;
                    end
                end
                OWN1: begin
                    if (!m1.req) begin
                        if (m0.req) begin
                            r_state <= OWN0;
                            r_prio  <= 1'b1;
                            r_hold  <= HW'(1);
                        end else begin
                            r_state <= IDLE;
                            r_hold  <= '0;
                        end
                    end else if (w_hold_done && m0.req && !m1.lock) begin
                        r_state <= OWN0;
                        r_prio  <= 1'b1;
                        r_hold  <= '0;
                    end else begin
                        r_hold <= w_hold_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_hold  <= '0;
                end
            endcase
        end
    end

    rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_push (s_re),
        .i_id   (w_gnt1),
        .o_vld  (w_tag_vld),
        .o_id   (w_tag_id)
    );

    // Return stage: capture slave data and steer the valid to the tagged master
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rvalid0 <= w_tag_vld & (w_tag_id == 1'b0);
            r_rvalid1 <= w_tag_vld & (w_tag_id == 1'b1);
            if (w_tag_vld) begin
                r_rdata <= s_rdata;
            end
        end
    end

    assign m0.gnt    = w_gnt0;
    assign m1.gnt    = w_gnt1;
    assign m0.rvalid = r_rvalid0;
    assign m1.rvalid = r_rvalid1;
    assign m0.rdata  = r_rdata;
    assign m1.rdata  = r_rdata;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed bench for mem_bus_arb: reset, single read, round-robin, lock,
// interleaved reads with a coincident write, and reset during a read.
module tb_mem_bus_arb;
    localparam int AW       = 16;
    localparam int DW       = 32;
    localparam int RD_LAT   = 1;
    localparam int MAX_HOLD = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] s_addr;
    logic          s_re;
    logic          s_we;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;
    int c0;
    int c1;

    mem_bus_arb_if #(.AW(AW), .DW(DW)) u_m0 ();
    mem_bus_arb_if #(.AW(AW), .DW(DW)) u_m1 ();

    mem_bus_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .m0      (u_m0),
        .m1      (u_m1),
        .s_addr  (s_addr),
        .s_re    (s_re),
        .s_we    (s_we),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
        return (a == 16'h0040) ? 32'hDEAD_BEEF : {16'hA5A5, a};
    endfunction

    // Slave with one cycle of read latency
    always @(posedge clk) begin
        if (s_re) s_rdata <= slave_data(s_addr);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        u_m0.req = 1'b1; u_m0.we = 1'b0; u_m0.addr = 16'h0100; u_m0.wdata = 32'h1111_0000; u_m0.lock = 1'b1;
        u_m1.req = 1'b1; u_m1.we = 1'b0; u_m1.addr = 16'h0200; u_m1.wdata = 32'h2222_0000; u_m1.lock = 1'b1;
        next_cyc();

        // Reset held with both masters requesting and locked
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_strobes", {u_m0.gnt, u_m1.gnt, u_m0.rvalid, u_m1.rvalid, s_re, s_we}, 64'd0);
            check_eq("rst_bus", {s_addr, s_wdata}, 64'd0);
            check_eq("rst_rdata", u_m0.rdata, 64'd0);
            next_cyc();
        end
        rst = 1'b0;
        @(negedge clk);
        check_eq("rel_idle", {u_m0.gnt, u_m1.gnt}, 64'd0);
        next_cyc();

        // Round-robin: 16 grants each, alternating, no bubbles
        u_m0.lock = 1'b0; u_m1.lock = 1'b0;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            check_eq("rr_gnt", {u_m0.gnt, u_m1.gnt}, (((i / 16) % 2) == 0) ? 64'd2 : 64'd1);
            c0 += int'(u_m0.gnt);
            c1 += int'(u_m1.gnt);
            next_cyc();
        end
        check_eq("rr_m0_total", c0, 64'd32);
        check_eq("rr_m1_total", c1, 64'd32);

        // Lock holds ownership past MAX_HOLD
        u_m0.lock = 1'b1;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            c0 += int'(u_m0.gnt);
            c1 += int'(u_m1.gnt);
            next_cyc();
        end
        check_eq("lock40_m0", c0, 64'd40);
        check_eq("lock40_m1", c1, 64'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            c0 += int'(u_m0.gnt);
            c1 += int'(u_m1.gnt);
            next_cyc();
        end
        check_eq("lock60_m0", c0, 64'd60);
        check_eq("lock60_m1", c1, 64'd0);
        u_m0.lock = 1'b0;
        @(negedge clk);
        check_eq("unlock_last_m0", {u_m0.gnt, u_m1.gnt}, 64'd2);
        next_cyc();
        @(negedge clk);
        check_eq("unlock_preempt", {u_m0.gnt, u_m1.gnt}, 64'd1);
        next_cyc();

        // Drain to IDLE
        u_m0.req = 1'b0; u_m1.req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("idle_gnt", {u_m0.gnt, u_m1.gnt}, 64'd0);
            next_cyc();
        end

        // Single read from idle
        u_m0.req = 1'b1; u_m0.we = 1'b0; u_m0.addr = 16'h0040;
        @(negedge clk);
        check_eq("rd_n_gnt", u_m0.gnt, 64'd0);
        next_cyc();
        @(negedge clk);
        check_eq("rd_gnt_re", {u_m0.gnt, s_re, s_we}, 64'd6);
        check_eq("rd_addr", s_addr, 64'h0040);
        next_cyc();
        u_m0.req = 1'b0;
        @(negedge clk);
        check_eq("rd_early", {u_m0.rvalid, u_m1.rvalid}, 64'd0);
        next_cyc();
        @(negedge clk);
        check_eq("rd_rvalid", {u_m0.rvalid, u_m1.rvalid}, 64'd2);
        check_eq("rd_data", u_m0.rdata, 64'hDEAD_BEEF);
        next_cyc();
        @(negedge clk);
        check_eq("rd_one_shot", {u_m0.rvalid, u_m1.rvalid}, 64'd0);
        next_cyc();

        // Interleaved reads m0 then m1, then an m1 write while m0's data returns
        u_m0.req = 1'b1; u_m0.addr = 16'h0010;
        @(negedge clk);
        next_cyc();
        @(negedge clk);
        check_eq("il_m0_gnt", {u_m0.gnt, s_re}, 64'd3);
        next_cyc();
        u_m0.req = 1'b0;
        u_m1.req = 1'b1; u_m1.we = 1'b0; u_m1.addr = 16'h0020;
        @(negedge clk);
        check_eq("il_handoff", {u_m0.gnt, u_m1.gnt, s_re}, 64'd3);
        check_eq("il_m1_addr", s_addr, 64'h0020);
        next_cyc();
        u_m1.we = 1'b1; u_m1.addr = 16'h0030; u_m1.wdata = 32'h1234_5678;
        @(negedge clk);
        check_eq("il_m0_rvalid", {u_m0.rvalid, u_m1.rvalid}, 64'd2);
        check_eq("il_m0_data", u_m0.rdata, 64'hA5A5_0010);
        check_eq("il_wr_strobe", {u_m1.gnt, s_we, s_re}, 64'd6);
        check_eq("il_wdata", s_wdata, 64'h1234_5678);
        next_cyc();
        u_m1.req = 1'b0; u_m1.we = 1'b0;
        @(negedge clk);
        check_eq("il_m1_rvalid", {u_m0.rvalid, u_m1.rvalid}, 64'd1);
        check_eq("il_m1_data", u_m1.rdata, 64'hA5A5_0020);
        next_cyc();
        @(negedge clk);
        check_eq("il_wr_no_rvalid", {u_m0.rvalid, u_m1.rvalid}, 64'd0);
        next_cyc();

        // Reset the cycle after a read strobe
        u_m0.req = 1'b1; u_m0.addr = 16'h0040;
        @(negedge clk);
        next_cyc();
        @(negedge clk);
        check_eq("mr_re", s_re, 64'd1);
        next_cyc();
        rst = 1'b1; u_m0.req = 1'b0;
        @(negedge clk);
        check_eq("mr_rv0", {u_m0.rvalid, u_m1.rvalid}, 64'd0);
        next_cyc();
        rst = 1'b0; u_m0.req = 1'b1;
        @(negedge clk);
        check_eq("mr_rv1", {u_m0.rvalid, u_m1.rvalid}, 64'd0);
        check_eq("mr_idle", {u_m0.gnt, u_m1.gnt}, 64'd0);
        check_eq("mr_rdata_clr", u_m0.rdata, 64'd0);
        next_cyc();
        @(negedge clk);
        check_eq("mr_rv2", {u_m0.rvalid, u_m1.rvalid}, 64'd0);
        check_eq("mr_regrant", {u_m0.gnt, u_m1.gnt}, 64'd2);
        next_cyc();
        u_m0.req = 1'b0;
        next_cyc();
        next_cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
